mips_debug_frame_tx: RTL and testbench

MIPS-side responder of the MicroBlaze debug link. It answers read requests issued by the blaze-side command decoder, which drives read_request and request_select.
- On a request it snapshots the selected source: a single 32-bit word (register, PC, data/instruction memory) or a wide pipeline latch group.
- It streams the snapshot to the blaze as consecutive 32-bit frames under a valid/ack handshake.
- It flags the last frame with EOD and reports end-of-program with EOP.

---
 rtl/mips_debug_pkg.sv | 45 ++++
 rtl/debug_frame_shifter.sv | 59 +++++
 rtl/mips_debug_frame_tx.sv | 200 ++++++++++++++++++++
 tb/tb_mips_debug_frame_tx.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/mips_debug_pkg.sv
// rtl/mips_debug_pkg.sv - shared select codes, state encoding and select-class decode for the debug link
package mips_debug_pkg;

    localparam int NB_CONTROL_FRAME = 32;
    localparam int NB_SELECT        = 6;

    // Select codes shared with the blaze-side command decoder.
    localparam logic [5:0] SEL_MEM_DATA  = 6'b100000;
    localparam logic [5:0] SEL_MEM_INSTR = 6'b100001;
    localparam logic [5:0] SEL_PC        = 6'b100010;

    // Latch groups occupy 1001xx and 1010xx; only the upper four bits identify them.
    localparam logic [3:0] SEL_LATCH_A_PREFIX = 4'b1001;
    localparam logic [3:0] SEL_LATCH_B_PREFIX = 4'b1010;

    localparam logic [1:0] ST_IDLE_ENC = 2'd0;
    localparam logic [1:0] ST_SEND_ENC = 2'd1;
    localparam logic [1:0] ST_DONE_ENC = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = ST_IDLE_ENC,
        ST_SEND = ST_SEND_ENC,
        ST_DONE = ST_DONE_ENC
    } state_t;

    typedef enum logic [1:0] {
        CLS_WORD     = 2'd0,
        CLS_LATCH    = 2'd1,
        CLS_UNMAPPED = 2'd2
    } sel_class_t;

    function automatic sel_class_t decode_select(input logic [NB_SELECT-1:0] sel);
        sel_class_t cls;
        cls = CLS_UNMAPPED;
        if (!sel[5]) begin
            cls = CLS_WORD;
        end else if (sel == SEL_MEM_DATA || sel == SEL_MEM_INSTR || sel == SEL_PC) begin
            cls = CLS_WORD;
        end else if (sel[5:2] == SEL_LATCH_A_PREFIX || sel[5:2] == SEL_LATCH_B_PREFIX) begin
            cls = CLS_LATCH;
        end
        return cls;
    endfunction

endpackage

// File: rtl/debug_frame_shifter.sv
// rtl/debug_frame_shifter.sv - snapshot register with frame index slicing and last-frame flag
//
// Ports:
//   i_clock, i_reset   clock, asynchronous active-low reset
//   i_load             capture i_load_data / i_load_count, index restarts at 0
//   i_load_data        snapshot source, NB_LATCH bits
//   i_load_count       number of frames in this transfer (1..NB_FRAMES)
//   i_advance          step to the next frame
//   o_frame            current NB_FRAME-bit slice, least-significant word first
//   o_last             current index is the final frame of the transfer
module debug_frame_shifter
    import mips_debug_pkg::*;
#(
    parameter int   NB_LATCH  = 128,
    parameter int   NB_FRAME  = 32,
    localparam int  NB_FRAMES = (NB_LATCH + NB_FRAME - 1) / NB_FRAME,
    localparam int  NB_IDX    = $clog2(NB_FRAMES + 1)
) (
    input  logic                i_clock,
    input  logic                i_reset,
    input  logic                i_load,
    input  logic [NB_LATCH-1:0] i_load_data,
    input  logic [NB_IDX-1:0]   i_load_count,
    input  logic                i_advance,
    output logic [NB_FRAME-1:0] o_frame,
    output logic                o_last
);

    // Padded to a whole number of frames so the top slice reads zeros past NB_LATCH.
    localparam int NB_PAD = NB_FRAMES * NB_FRAME;

    logic [NB_PAD-1:0] r_snapshot;
    logic [NB_IDX-1:0] r_index;
    logic [NB_IDX-1:0] r_count;
    logic [NB_PAD-1:0] w_load_ext;

    always_comb begin
        w_load_ext                 = '0;
        w_load_ext[NB_LATCH-1:0]   = i_load_data;
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_snapshot <= '0;
            r_index    <= '0;
            r_count    <= '0;
        end else if (i_load) begin
            r_snapshot <= w_load_ext;
            r_index    <= '0;
            r_count    <= i_load_count;
        end else if (i_advance) begin
            r_index    <= r_index + NB_IDX'(1);
        end
    end

    assign o_frame = r_snapshot[int'(r_index) * NB_FRAME +: NB_FRAME];
    assign o_last  = (r_index == r_count - NB_IDX'(1));

endmodule

// File: rtl/mips_debug_frame_tx.sv
// rtl/mips_debug_frame_tx.sv - MIPS-side debug responder streaming word/latch snapshots as 32-bit frames
//
// Optional feature macro: DEBUG_TX_TIMEOUT_EN (ack timeout with o_timeout pulse)
//
// Ports:
//   i_clock, i_reset     clock, asynchronous active-low reset
//   i_read_request       one-cycle request pulse from the command decoder
//   i_request_select     source code (register / data mem / instr mem / PC / latch groups)
//   i_word_data          selected 32-bit word source
//   i_latch_data         selected latch group
//   i_halt               MIPS end of program
//   i_frame_ack          blaze consumed the current frame
//   o_frame_to_blaze     current frame payload
//   o_frame_valid        payload valid
//   o_eod                current frame is the last of the transfer
//   o_eop                i_halt delayed one cycle
//   o_busy               transfer in progress
//   o_timeout            (DEBUG_TX_TIMEOUT_EN only) one-cycle pulse on ack timeout abort
module mips_debug_frame_tx
    import mips_debug_pkg::*;
#(
    parameter int  NB_CONTROL_FRAME = 32,
    parameter int  NB_LATCH         = 128,
    parameter int  NB_SELECT        = 6,
    parameter int  TIMEOUT_CYCLES   = 1024
) (
    input  logic                        i_clock,
    input  logic                        i_reset,
    input  logic                        i_read_request,
    input  logic [NB_SELECT-1:0]        i_request_select,
    input  logic [NB_CONTROL_FRAME-1:0] i_word_data,
    input  logic [NB_LATCH-1:0]         i_latch_data,
    input  logic                        i_halt,
    input  logic                        i_frame_ack,
    output logic [NB_CONTROL_FRAME-1:0] o_frame_to_blaze,
    output logic                        o_frame_valid,
    output logic                        o_eod,
    output logic                        o_eop,
    output logic                        o_busy
`ifdef DEBUG_TX_TIMEOUT_EN
    ,
    output logic                        o_timeout
`endif
);

    localparam int NB_FRAMES_L = (NB_LATCH + NB_CONTROL_FRAME - 1) / NB_CONTROL_FRAME;
    localparam int NB_IDX      = $clog2(NB_FRAMES_L + 1);

    state_t                       r_state;
    logic                         r_valid;
    logic                         r_busy;
    logic                         r_eop;

    sel_class_t                   w_class;
    logic [NB_LATCH-1:0]          w_capture;
    logic [NB_IDX-1:0]            w_count;
    logic                         w_load;
    logic                         w_advance;
    logic                         w_last;
    logic [NB_CONTROL_FRAME-1:0]  w_frame;

    // Unmapped codes fall through with an all-zero capture and a single frame.
    always_comb begin
        w_class   = decode_select(i_request_select);
        w_capture = '0;
        w_count   = NB_IDX'(1);
        case (w_class)
            CLS_WORD:  w_capture[NB_CONTROL_FRAME-1:0] = i_word_data;
            CLS_LATCH: begin
                w_capture = i_latch_data;
                w_count   = NB_IDX'(NB_FRAMES_L);
            end
            default:   w_capture = '0;
        endcase
    end

    assign w_load    = (r_state == ST_IDLE) && i_read_request;
    assign w_advance = (r_state == ST_SEND) && i_frame_ack && !w_last;

    debug_frame_shifter #(
        .NB_LATCH (NB_LATCH),
        .NB_FRAME (NB_CONTROL_FRAME)
    ) u_shifter (
        .i_clock      (i_clock),
        .i_reset      (i_reset),
        .i_load       (w_load),
        .i_load_data  (w_capture),
        .i_load_count (w_count),
        .i_advance    (w_advance),
        .o_frame      (w_frame),
        .o_last       (w_last)
    );

`ifdef DEBUG_TX_TIMEOUT_EN
    localparam int NB_TO = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [NB_TO-1:0] r_to_cnt;
    logic             r_timeout;

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_state   <= ST_IDLE;
            r_valid   <= 1'b0;
            r_busy    <= 1'b0;
            r_to_cnt  <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_to_cnt <= '0;
                    if (i_read_request) begin
                        r_state <= ST_SEND;
                        r_valid <= 1'b1;
                        r_busy  <= 1'b1;
                    end
                end
                ST_SEND: begin
                    if (i_frame_ack) begin
                        r_to_cnt <= '0;
                        if (w_last) begin
                            r_state <= ST_DONE;
                            r_valid <= 1'b0;
                            r_busy  <= 1'b0;
                        end
                    end else if (r_to_cnt == NB_TO'(TIMEOUT_CYCLES - 1)) begin
                        // Abort without ever presenting an EOD frame.
                        r_state   <= ST_DONE;
                        r_valid   <= 1'b0;
                        r_busy    <= 1'b0;
                        r_timeout <= 1'b1;
                        r_to_cnt  <= '0;
                    end else begin
                        r_to_cnt <= r_to_cnt + NB_TO'(1);
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_valid <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_timeout = r_timeout;
`else
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_state <= ST_IDLE;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_read_request) begin
                        r_state <= ST_SEND;
                        r_valid <= 1'b1;
                        r_busy  <= 1'b1;
                    end
                end
                ST_SEND: begin
                    if (i_frame_ack && w_last) begin
                        r_state <= ST_DONE;
                        r_valid <= 1'b0;
                        r_busy  <= 1'b0;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_valid <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end
`endif

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_eop <= 1'b0;
        end else begin
            r_eop <= i_halt;
        end
    end

    // Payload and EOD are qualified by the registered valid so they drop with it.
    assign o_frame_to_blaze = r_valid ? w_frame : '0;
    assign o_frame_valid    = r_valid;
    assign o_eod            = r_valid && w_last;
    assign o_busy           = r_busy;
    assign o_eop            = r_eop;

endmodule

// File: tb/tb_mips_debug_frame_tx.sv
// tb/tb_mips_debug_frame_tx.sv - directed self-checking bench for mips_debug_frame_tx
module tb_mips_debug_frame_tx;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req, req72;
    logic [5:0]   sel;
    logic [31:0]  word;
    logic [127:0] latch;
    logic [71:0]  latch72;
    logic         halt;
    logic         ack, ack72;

    logic [31:0]  frame, frame72;
    logic         valid, valid72, eod, eod72, eop, eop72, busy, busy72;
`ifdef DEBUG_TX_TIMEOUT_EN
    logic         timeout, timeout72;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mips_debug_frame_tx #(.NB_LATCH(128), .TIMEOUT_CYCLES(8)) u_dut (
        .i_clock          (clk),
        .i_reset          (rst_n),
        .i_read_request   (req),
        .i_request_select (sel),
        .i_word_data      (word),
        .i_latch_data     (latch),
        .i_halt           (halt),
        .i_frame_ack      (ack),
        .o_frame_to_blaze (frame),
        .o_frame_valid    (valid),
        .o_eod            (eod),
        .o_eop            (eop),
        .o_busy           (busy)
`ifdef DEBUG_TX_TIMEOUT_EN
        ,
        .o_timeout        (timeout)
`endif
    );

    mips_debug_frame_tx #(.NB_LATCH(72), .TIMEOUT_CYCLES(8)) u_dut72 (
        .i_clock          (clk),
        .i_reset          (rst_n),
        .i_read_request   (req72),
        .i_request_select (sel),
        .i_word_data      (word),
        .i_latch_data     (latch72),
        .i_halt           (halt),
        .i_frame_ack      (ack72),
        .o_frame_to_blaze (frame72),
        .o_frame_valid    (valid72),
        .o_eod            (eod72),
        .o_eop            (eop72),
        .o_busy           (busy72)
`ifdef DEBUG_TX_TIMEOUT_EN
        ,
        .o_timeout        (timeout72)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_hs(input string tag, input logic [31:0] f, input logic v,
                            input logic e, input logic b);
        check({tag, "_frame"}, frame, f);
        check({tag, "_valid"}, {31'b0, valid}, {31'b0, v});
        check({tag, "_eod"},   {31'b0, eod},   {31'b0, e});
        check({tag, "_busy"},  {31'b0, busy},  {31'b0, b});
    endtask

    logic [31:0] exp_lat [4];

    initial begin
        rst_n = 1'b0; req = 0; req72 = 0; sel = '0; word = '0; latch = '0;
        latch72 = '0; halt = 0; ack = 0; ack72 = 0;
        exp_lat[0] = 32'h1111_1111; exp_lat[1] = 32'h2222_2222;
        exp_lat[2] = 32'h3333_3333; exp_lat[3] = 32'h4444_4444;

        // Reset state
        tick(); tick();
        check_hs("reset", 32'h0, 1'b0, 1'b0, 1'b0);
        check("reset_eop", {31'b0, eop}, 32'h0);
        rst_n = 1'b1;
        tick();

        // Single word: register 5
        sel = 6'b000101; word = 32'hCAFE_0005; req = 1;
        tick();
        req = 0; word = 32'h0BAD_0BAD;
        check_hs("word", 32'hCAFE_0005, 1'b1, 1'b1, 1'b1);
        ack = 1; tick(); ack = 0;
        check_hs("word_done", 32'h0, 1'b0, 1'b0, 1'b0);
        tick();
        check_hs("word_idle", 32'h0, 1'b0, 1'b0, 1'b0);

        // Latch group: four frames, stray requests ignored, source changes ignored
        sel = 6'b100100;
        latch = {exp_lat[3], exp_lat[2], exp_lat[1], exp_lat[0]};
        req = 1; tick(); req = 0;
        latch = '1;
        check_hs("lat0", exp_lat[0], 1'b1, 1'b0, 1'b1);
        tick();
        check_hs("lat0_hold", exp_lat[0], 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            check_hs($sformatf("lat%0d", i), exp_lat[i], 1'b1, (i == 3), 1'b1);
            ack = 1; req = (i == 1 || i == 3);
            tick();
            ack = 0; req = 0;
        end
        check_hs("lat_done", 32'h0, 1'b0, 1'b0, 1'b0);
        req = 1; tick(); req = 0;
        check_hs("lat_req_in_done", 32'h0, 1'b0, 1'b0, 1'b0);
        tick();
        check_hs("lat_idle", 32'h0, 1'b0, 1'b0, 1'b0);

        // NB_LATCH=72: three frames, top one zero-padded
        latch72 = 72'hA5_DEAD_BEEF_1234_5678;
        req72 = 1; tick(); req72 = 0;
        check("l72_f0", frame72, 32'h1234_5678);
        check("l72_eod0", {31'b0, eod72}, 32'h0);
        ack72 = 1; tick();
        check("l72_f1", frame72, 32'hDEAD_BEEF);
        check("l72_valid1", {31'b0, valid72}, 32'h1);
        tick();
        check("l72_f2", frame72, 32'h0000_00A5);
        check("l72_eod2", {31'b0, eod72}, 32'h1);
        tick(); ack72 = 0;
        check("l72_done_valid", {31'b0, valid72}, 32'h0);

        // Unmapped code: one zero frame with EOD
        tick();
        sel = 6'b110000; word = 32'h1234_ABCD; req = 1; tick(); req = 0;
        check_hs("unmapped", 32'h0, 1'b1, 1'b1, 1'b1);
        ack = 1; tick(); ack = 0; tick();

        // PC word
        sel = 6'b100010; word = 32'h0040_0010; req = 1; tick(); req = 0;
        check_hs("pc", 32'h0040_0010, 1'b1, 1'b1, 1'b1);
        ack = 1; tick(); ack = 0; tick();

        // EOP follows halt by one cycle
        halt = 1; #1;
        check("eop_pre", {31'b0, eop}, 32'h0);
        tick();
        check("eop_set", {31'b0, eop}, 32'h1);
        halt = 0; tick();
        check("eop_clr", {31'b0, eop}, 32'h0);

        // Asynchronous reset mid-transfer
        sel = 6'b101000;
        latch = {exp_lat[3], exp_lat[2], exp_lat[1], exp_lat[0]};
        req = 1; tick(); req = 0;
        ack = 1; tick(); ack = 0;
        check_hs("pre_rst", exp_lat[1], 1'b1, 1'b0, 1'b1);
        #2 rst_n = 1'b0; #1;
        check_hs("async_rst", 32'h0, 1'b0, 1'b0, 1'b0);
        tick();
        rst_n = 1'b1;
        tick();
        check_hs("post_rst", 32'h0, 1'b0, 1'b0, 1'b0);

`ifdef DEBUG_TX_TIMEOUT_EN
        // No ack: abort after the 8th SEND cycle
        sel = 6'b000001; word = 32'h5A5A_5A5A; req = 1; tick(); req = 0;
        for (int k = 1; k < 8; k++) tick();
        check("to_valid_before", {31'b0, valid}, 32'h1);
        check("to_pulse_before", {31'b0, timeout}, 32'h0);
        tick();
        check("to_pulse", {31'b0, timeout}, 32'h1);
        check("to_valid_after", {31'b0, valid}, 32'h0);
        tick();
        check("to_pulse_clear", {31'b0, timeout}, 32'h0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
